iq_unpack: RTL and testbench

//   Front-end stage of the FM receive chain: drains the raw byte FIFO, assembles

---
 rtl/iq_unpack.sv | 189 ++++++++++++++++++
 tb/tb_iq_unpack.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_unpack.sv
// ---------------------------------------------------------------------------
// iq_unpack
//
// Front-end stage of the FM receive chain. Drains a first-word-fall-through
// byte FIFO and assembles little-endian 16-bit signed I/Q pairs. The byte
// order is I_lo, I_hi, Q_lo, Q_hi. Each pair is sign-extended to DATA_WIDTH
// and shifted left by QUANT_BITS, giving a Q(DATA_WIDTH-QUANT_BITS).QUANT_BITS
// value. The result is pushed into the I and Q FIFOs in the same cycle.
// Four input bytes produce one output pair, at most one pair every 5 cycles.
//
// Optional feature (compile-time macro):
//   IQ_UNPACK_STATS_EN  adds output sample_count[31:0], which counts written
//                       pairs since reset and wraps at 2^32.
//
// Ports:
//   clock         in   system clock, all state on the rising edge
//   reset         in   synchronous, active-low reset
//   in_dout       in   byte at the head of the input FIFO (valid while !in_empty)
//   in_empty      in   input FIFO empty
//   in_rd_en      out  pop the input FIFO this cycle
//   i_out         out  quantised I sample (zero unless i_wr_en)
//   i_wr_en       out  push i_out into the I FIFO
//   i_full        in   I FIFO full
//   q_out         out  quantised Q sample (zero unless q_wr_en)
//   q_wr_en       out  push q_out into the Q FIFO
//   q_full        in   Q FIFO full
//   sample_count  out  pairs written since reset (IQ_UNPACK_STATS_EN only)
//
// Parameters:
//   DATA_WIDTH  width of i_out/q_out; must be >= 2*BYTE_WIDTH + QUANT_BITS
//   BYTE_WIDTH  width of an input FIFO word
//   QUANT_BITS  fractional bits (left shift after sign extension)
// ---------------------------------------------------------------------------
module iq_unpack #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int QUANT_BITS = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [BYTE_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] i_out,
    output logic                  i_wr_en,
    input  logic                  i_full,
    output logic [DATA_WIDTH-1:0] q_out,
    output logic                  q_wr_en,
    input  logic                  q_full
`ifdef IQ_UNPACK_STATS_EN
    ,
    output logic [31:0]           sample_count
`endif
);

    localparam int PAIR_WIDTH = 2 * BYTE_WIDTH;

    // One state per byte of the pair, then one state to hand the pair off.
    typedef enum logic [2:0] {
        I_LO,
        I_HI,
        Q_LO,
        Q_HI,
        WRITE
    } state_t;

    state_t                state;
    logic [BYTE_WIDTH-1:0] i_lo;
    logic [BYTE_WIDTH-1:0] i_hi;
    logic [BYTE_WIDTH-1:0] q_lo;
    logic [BYTE_WIDTH-1:0] q_hi;

    logic                  read_state;
    logic                  wr_fire;
    logic [DATA_WIDTH-1:0] i_quant;
    logic [DATA_WIDTH-1:0] q_quant;

    // Sign-extend a {hi,lo} word to DATA_WIDTH and apply the fixed-point
    // scaling. Nothing saturates: the width rule on DATA_WIDTH keeps every
    // 16-bit input representable.
    function automatic logic [DATA_WIDTH-1:0] quantise(
        input logic [BYTE_WIDTH-1:0] hi,
        input logic [BYTE_WIDTH-1:0] lo
    );
        logic signed [PAIR_WIDTH-1:0] raw;
        logic signed [DATA_WIDTH-1:0] ext;
        raw = {hi, lo};
        ext = DATA_WIDTH'(raw);
        return ext <<< QUANT_BITS;
    endfunction

    assign i_quant = quantise(i_hi, i_lo);
    assign q_quant = quantise(q_hi, q_lo);

    // NOTE: the FIFO handshakes cannot be registered. The input FIFO is
    // fall-through, so the pop must react to in_empty in the same cycle.
    // A write must likewise be dropped in the same cycle that either
    // downstream FIFO reports full. The handshakes are therefore decoded
    // from the registered state and the current flags. Reset gates them,
    // so the block is silent while reset is held.
    assign read_state = (state == I_LO) || (state == I_HI) ||
                        (state == Q_LO) || (state == Q_HI);

    // Both FIFOs are written together or not at all. Either one being full
    // stalls the pair.
    assign wr_fire = reset && (state == WRITE) && !i_full && !q_full;

    // NOTE: every output written in always_comb gets a default first. An
    // output that is not assigned on some path would infer a latch.
    always_comb begin
        in_rd_en = 1'b0;
        i_wr_en  = 1'b0;
        q_wr_en  = 1'b0;
        i_out    = '0;
        q_out    = '0;
        if (reset && read_state && !in_empty) begin
            in_rd_en = 1'b1;
        end
        if (wr_fire) begin
            i_wr_en = 1'b1;
            q_wr_en = 1'b1;
            i_out   = i_quant;
            q_out   = q_quant;
        end
    end

    // A reset in the middle of a pair discards the partial bytes. The next
    // byte after release is treated as I_lo.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= I_LO;
            i_lo  <= '0;
            i_hi  <= '0;
            q_lo  <= '0;
            q_hi  <= '0;
        end else begin
            case (state)
                I_LO: begin
                    if (in_rd_en) begin
                        i_lo  <= in_dout;
                        state <= I_HI;
                    end
                end
                I_HI: begin
                    if (in_rd_en) begin
                        i_hi  <= in_dout;
                        state <= Q_LO;
                    end
                end
                Q_LO: begin
                    if (in_rd_en) begin
                        q_lo  <= in_dout;
                        state <= Q_HI;
                    end
                end
                Q_HI: begin
                    if (in_rd_en) begin
                        q_hi  <= in_dout;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    // No byte is read here. The assembled pair stays put
                    // until both FIFOs can take it.
                    if (wr_fire) begin
                        state <= I_LO;
                    end
                end
                default: begin
                    state <= I_LO;
                end
            endcase
        end
    end

`ifdef IQ_UNPACK_STATS_EN
    // Pair counter. It wraps naturally at 2^32.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sample_count <= '0;
        end else if (wr_fire) begin
            sample_count <= sample_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_iq_unpack.sv
// ---------------------------------------------------------------------------
// tb_iq_unpack
//
// Self-checking bench for iq_unpack. A byte queue feeds the fall-through
// input. Expected I/Q values sit in queues and are compared whenever the DUT
// writes. Directed pairs come from a vector table with hand-computed
// results. Random pairs get their expected values from plain signed
// arithmetic (value * 2^10). Define IQ_UNPACK_STATS_EN to also check
// sample_count.
// ---------------------------------------------------------------------------
module tb_iq_unpack;

    localparam int DW = 32;
    localparam int BW = 8;
    localparam int QB = 10;

    logic          clock = 1'b0;
    logic          reset;
    logic [BW-1:0] in_dout;
    logic          in_empty;
    logic          in_rd_en;
    logic [DW-1:0] i_out;
    logic          i_wr_en;
    logic          i_full;
    logic [DW-1:0] q_out;
    logic          q_wr_en;
    logic          q_full;
`ifdef IQ_UNPACK_STATS_EN
    logic [31:0]   sample_count;
`endif

    always #5 clock = ~clock;

    iq_unpack #(
        .DATA_WIDTH(DW),
        .BYTE_WIDTH(BW),
        .QUANT_BITS(QB)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .in_dout (in_dout),
        .in_empty(in_empty),
        .in_rd_en(in_rd_en),
        .i_out   (i_out),
        .i_wr_en (i_wr_en),
        .i_full  (i_full),
        .q_out   (q_out),
        .q_wr_en (q_wr_en),
        .q_full  (q_full)
`ifdef IQ_UNPACK_STATS_EN
        ,
        .sample_count(sample_count)
`endif
    );

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp_i, exp_q;
    } vec_t;

    vec_t        vecs[5];
    logic [7:0]  src_q[$];
    logic [31:0] exp_i_q[$];
    logic [31:0] exp_q_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_pop_cyc = 0;
    int last_wr_cyc = 0;
    int wr_count = 0;
    int empty_pct = 0;
    int full_pct = 0;
    bit force_empty = 1'b0;
    bit force_qfull = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: sign-extend the 16-bit word, then scale by 2^QB.
    function automatic logic [31:0] model(input logic [15:0] w);
        int v;
        v = int'(shortint'(w));
        return 32'(v * (1 << QB));
    endfunction

    task automatic push_pair(input logic [15:0] iv, input logic [15:0] qv);
        src_q.push_back(iv[7:0]);
        src_q.push_back(iv[15:8]);
        src_q.push_back(qv[7:0]);
        src_q.push_back(qv[15:8]);
        exp_i_q.push_back(model(iv));
        exp_q_q.push_back(model(qv));
    endtask

    task automatic push_vec(input vec_t v);
        src_q.push_back(v.b0);
        src_q.push_back(v.b1);
        src_q.push_back(v.b2);
        src_q.push_back(v.b3);
        exp_i_q.push_back(v.exp_i);
        exp_q_q.push_back(v.exp_q);
    endtask

    // One clock cycle. Entered and left 1 time unit after a rising edge.
    // Inputs are driven first, then outputs are sampled mid-cycle.
    task automatic step();
        in_empty = force_empty || (src_q.size() == 0) ||
                   (int'($urandom_range(99)) < empty_pct);
        in_dout  = in_empty ? 8'($urandom) : src_q[0];
        i_full   = (int'($urandom_range(99)) < full_pct);
        q_full   = force_qfull || (int'($urandom_range(99)) < full_pct);
        #2;
        if (!reset) begin
            check("reset_rd_en", 32'(in_rd_en), 32'd0);
            check("reset_wr_en", 32'({i_wr_en, q_wr_en}), 32'd0);
            check("reset_out", i_out | q_out, 32'd0);
        end else begin
            if (in_rd_en) begin
                if (in_empty) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_en_while_empty actual=1 expected=0 (cycle %0d)", cyc);
                end else begin
                    void'(src_q.pop_front());
                    last_pop_cyc = cyc;
                end
            end
            if (i_wr_en || q_wr_en) begin
                check("wr_en_pair", 32'({i_wr_en, q_wr_en}), 32'd3);
                check("wr_while_full", 32'({i_full, q_full}), 32'd0);
                if (exp_i_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write i=%h q=%h expected=none (cycle %0d)",
                             i_out, q_out, cyc);
                end else begin
                    check("i_out", i_out, exp_i_q.pop_front());
                    check("q_out", q_out, exp_q_q.pop_front());
                end
                wr_count++;
                last_wr_cyc = cyc;
            end else begin
                check("idle_out_zero", i_out | q_out, 32'd0);
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic wait_wr(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (wr_count < target && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(wr_count), 32'(target));
    endtask

    task automatic drain_src(input string name, input int keep, input int budget);
        int n;
        n = 0;
        while (src_q.size() > keep && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(src_q.size()), 32'(keep));
    endtask

    initial begin
        int base;
        vecs[0] = '{8'h01, 8'h00, 8'hFF, 8'hFF, 32'h0000_0400, 32'hFFFF_FC00};
        vecs[1] = '{8'hFF, 8'h7F, 8'h00, 8'h80, 32'h01FF_FC00, 32'hFE00_0000};
        vecs[2] = '{8'h00, 8'h01, 8'h00, 8'h02, 32'h0004_0000, 32'h0008_0000};
        vecs[3] = '{8'h34, 8'h12, 8'hCC, 8'hED, 32'h0048_D000, 32'hFFB7_3000};
        vecs[4] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 32'hFFFF_FC00, 32'h0000_0000};

        reset    = 1'b0;
        in_empty = 1'b1;
        in_dout  = '0;
        i_full   = 1'b0;
        q_full   = 1'b0;
        @(posedge clock);
        #1;

        // Reset held with bytes available: nothing may be popped or written.
        src_q.push_back(8'hAA);
        src_q.push_back(8'hBB);
        repeat (3) step();
        check("reset_no_pop", 32'(src_q.size()), 32'd2);
        src_q.delete();
        reset = 1'b1;
`ifdef IQ_UNPACK_STATS_EN
        check("count_after_reset", sample_count, 32'd0);
`endif

        // Table-driven pairs, no stalls: one pulse, 1 cycle after the last pop.
        foreach (vecs[k]) begin
            base = wr_count;
            push_vec(vecs[k]);
            wait_wr("vec_write", base + 1, 40);
            check("vec_latency", 32'(last_wr_cyc - last_pop_cyc), 32'd1);
            repeat (3) step();
            check("vec_single_pulse", 32'(wr_count), 32'(base + 1));
        end

        // Input empty for 7 cycles between byte 2 and byte 3.
        base = wr_count;
        push_vec(vecs[1]);
        drain_src("stall_first_two", 2, 20);
        force_empty = 1'b1;
        repeat (7) step();
        check("stall_bytes_kept", 32'(src_q.size()), 32'd2);
        force_empty = 1'b0;
        wait_wr("stall_write", base + 1, 40);

        // Q FIFO full for 5 cycles while the pair waits in WRITE.
        base = wr_count;
        push_vec(vecs[3]);
        drain_src("full_drain", 0, 20);
        force_qfull = 1'b1;
        repeat (5) step();
        check("full_held", 32'(wr_count), 32'(base));
        force_qfull = 1'b0;
        step();
        check("full_release_fire", 32'(wr_count), 32'(base + 1));

        // Reset after 3 bytes of a pair: the partial pair is dropped.
        base = wr_count;
        src_q.push_back(8'h11);
        src_q.push_back(8'h22);
        src_q.push_back(8'h33);
        drain_src("partial_drain", 0, 20);
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        push_vec(vecs[2]);
        wait_wr("after_reset_write", base + 1, 40);
        repeat (5) step();
        check("after_reset_one_pair", 32'(wr_count), 32'(base + 1));
        check("after_reset_exp_empty", 32'(exp_i_q.size()), 32'd0);

        // 1000 random pairs with random input gaps and full flags.
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
`ifdef IQ_UNPACK_STATS_EN
        check("count_cleared", sample_count, 32'd0);
`endif
        empty_pct = 20;
        full_pct  = 15;
        base = wr_count;
        for (int n = 0; n < 1000; n++) begin
            push_pair(16'($urandom), 16'($urandom));
        end
        wait_wr("random_writes", base + 1000, 40000);
        empty_pct = 0;
        full_pct  = 0;
        repeat (3) step();
        check("random_exp_empty", 32'(exp_i_q.size()), 32'd0);
        check("random_total", 32'(wr_count), 32'(base + 1000));
`ifdef IQ_UNPACK_STATS_EN
        check("sample_count", sample_count, 32'd1000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
